ret_uart_tx: RTL and testbench
==============================

Name: ret_uart_tx

Overview:
- Byte-wide asynchronous serial (UART) transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Lets the FPGA source the panel/PPS serial links (PPSTXD0/PPSTXD1) and the SC link itself instead of only passing LaunchPad traffic through.
- Sits in the CLK25M domain behind a valid/ready byte interface; the tx_o output is muxed onto the pad by the top level.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 baud); legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, "NONE", one of "NONE", "EVEN", "ODD".
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk_i  input  1  system clock (25 MHz)
- rst_i  input  1  synchronous active-high reset
- dat_i  input  DATA_BITS  byte to send; sampled only on acceptance
- valid_i  input  1  dat_i valid
- ready_o  output  1  transmitter can accept a byte
- tx_o  output  1  serial line; idle high
- busy_o  output  1  frame in progress
- done_o  output  1  one-cycle pulse at the end of the final stop bit

Behaviour:
- Reset: reset is synchronous and active-high. While rst_i is high: tx_o=1, ready_o=0, busy_o=0, done_o=0, state=IDLE, baud and bit counters=0.
- Post-reset: ready_o=1 on the first cycle after rst_i is sampled low.
- Acceptance: a byte is accepted when valid_i && ready_o at a clock edge.
  - dat_i is latched into the shift register.
  - On the next cycle: ready_o=0, busy_o=1, tx_o=0 (start bit). Latency from acceptance edge to start bit is 1 cycle.
  - valid_i with ready_o=0 is ignored; no queuing.
  - dat_i changes after acceptance have no effect.
- State machine: IDLE → START → DATA → (PARITY if PARITY≠"NONE") → STOP → IDLE.
  - IDLE: tx_o=1, ready_o=1; acceptance moves to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: tx_o=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; leave after DATA_BITS bits.
  - PARITY: tx_o = XOR of the latched data bits for EVEN, its complement for ODD; held CLKS_PER_BIT cycles.
  - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT). There is no drift: every bit is exactly CLKS_PER_BIT cycles.
- Bit counter: counts data bits and stop bits. Width is $clog2(DATA_BITS+1).
- done_o: asserted for exactly one cycle, on the last cycle of the final stop bit.
- Return to IDLE: on the following cycle, state=IDLE, ready_o=1, busy_o=0.
- Frame spacing: frame length F = (1 + DATA_BITS + (PARITY≠"NONE") + STOP_BITS) × CLKS_PER_BIT. Back-to-back frames (valid_i held high) have start-to-start spacing of exactly F+1 cycles; the extra IDLE cycle holds tx_o=1.
- Glitch-free output: tx_o is driven from a register, never from combinational logic.
- Reset mid-frame: the frame is aborted. tx_o=1 on the cycle after rst_i is sampled high, no done_o is issued, and the latched byte is discarded.
- Elaboration errors: CLKS_PER_BIT < 2, DATA_BITS outside 5..8, STOP_BITS outside 1..2, or an unknown PARITY string.

Test Plan:
- Basic frame (CLKS_PER_BIT=8, NONE, 1 stop): send 0xA5 → tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles, start bit 1 cycle after acceptance. done_o pulses 80 cycles after tx_o falls. ready_o=1 on the next cycle.
- Back-to-back: valid_i held with 0x00 then 0xFF → second start bit falls exactly 81 cycles after the first. Exactly two done_o pulses occur.
- Parity: EVEN with 0x07 → parity bit 1; ODD with 0x07 → 0; EVEN with 0x03 → 0. Frame is 11 bits (88 cycles).
- Two stop bits (STOP_BITS=2, byte 0x80) → tx_o high for 16 cycles after the MSB. done_o comes on the last of those cycles.
- Reset mid-frame: assert rst_i for 3 cycles during data bit 3 → tx_o=1 on the next cycle and ready_o=0 while in reset. ready_o=1 on the first cycle after release. No done_o occurs, and a new byte then transmits correctly.
- Ignored stimulus: pulse valid_i and toggle dat_i during DATA → the transmitted bits equal the originally accepted byte and no second frame starts. Default parameters give bit width = 217 cycles ±0.

Source files
------------

// File: rtl/ret_uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity
// bit, STOP_BITS stop bits. Every output is a flop, so tx_o never glitches.
module ret_uart_tx #(
  parameter int    CLKS_PER_BIT = 217,
  parameter int    DATA_BITS    = 8,
  parameter string PARITY       = "NONE",
  parameter int    STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] dat_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("ret_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("ret_uart_tx: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("ret_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY != "NONE" && PARITY != "EVEN" && PARITY != "ODD") begin : g_bad_parity
      $error("ret_uart_tx: PARITY must be NONE, EVEN or ODD");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 ready_reg, ready_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic accept;
  logic bit_end;

  // ready_reg is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept  = valid_i && ready_reg;
  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_cnt_reg == DATA_LAST) begin
          state_next = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end && bit_cnt_reg == STOP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Baud/bit counters and the data shifter
  always_comb begin
    baud_cnt_next = baud_cnt_reg + BAUD_ONE;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    if (state_reg == S_IDLE) begin
      baud_cnt_next = '0;
      bit_cnt_next  = '0;
      if (accept) begin
        shift_next  = dat_i;
        parity_next = (^dat_i) ^ PAR_ODD;
      end
    end else if (bit_end) begin
      baud_cnt_next = '0;
      case (state_reg)
        S_DATA: begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = (bit_cnt_reg == DATA_LAST) ? '0 : bit_cnt_reg + BIT_ONE;
        end
        S_STOP: begin
          bit_cnt_next = (bit_cnt_reg == STOP_LAST) ? '0 : bit_cnt_reg + BIT_ONE;
        end
        default: bit_cnt_next = bit_cnt_reg;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops aligned with it
  always_comb begin
    tx_next    = 1'b1;
    ready_next = (state_next == S_IDLE);
    busy_next  = (state_next != S_IDLE);
    done_next  = (state_next == S_STOP) && (baud_cnt_next == BAUD_LAST) &&
                 (bit_cnt_next == STOP_LAST);
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_next;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign tx_o    = tx_reg;
  assign ready_o = ready_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_ret_uart_tx.sv
// Bench for ret_uart_tx: five differently parameterised instances, a frame-level
// reference model compared every cycle, and directed frames with literal expectations.
module tb_ret_uart_tx;

  logic       clk;
  logic [4:0] rst;
  logic [4:0] valid;
  logic [7:0] dat [5];
  wire  [4:0] tx;
  wire  [4:0] ready;
  wire  [4:0] busy;
  wire  [4:0] done;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8 clk/bit, no parity, 1 stop   1: EVEN   2: ODD   3: 2 stop bits   4: defaults
  ret_uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .dat_i(dat[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  ret_uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .dat_i(dat[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  ret_uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .dat_i(dat[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  ret_uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(2)) u3 (
    .clk_i(clk), .rst_i(rst[3]), .dat_i(dat[3]), .valid_i(valid[3]),
    .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));
  ret_uart_tx u4 (
    .clk_i(clk), .rst_i(rst[4]), .dat_i(dat[4]), .valid_i(valid[4]),
    .ready_o(ready[4]), .tx_o(tx[4]), .busy_o(busy[4]), .done_o(done[4]));

  function automatic int cpb_of(input int k);
    return (k == 4) ? 217 : 8;
  endfunction

  function automatic int par_of(input int k);  // 0 none, 1 even, 2 odd
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * cpb_of(k);
  endfunction

  // Line level of serial bit slot idx of a frame carrying byte b.
  function automatic logic slot_level(input int k, input int idx, input logic [7:0] b);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par_of(k) != 0 && idx == 9) return (par_of(k) == 1) ? (^b) : ~(^b);
    return 1'b1;
  endfunction

  // Reference model: frame position counter, outputs as seen after each edge.
  bit       started = 1'b0;
  bit [4:0] m_tx, m_rdy, m_busy, m_done;
  int       m_t [5];
  logic [7:0] m_byte [5];

  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (rst[k]) begin
        m_busy[k] = 1'b0; m_rdy[k] = 1'b0; m_tx[k] = 1'b1; m_done[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (valid[k] && m_rdy[k]) begin
          m_byte[k] = dat[k];
          m_busy[k] = 1'b1; m_t[k] = 0; m_rdy[k] = 1'b0; m_tx[k] = 1'b0; m_done[k] = 1'b0;
        end else begin
          m_rdy[k] = 1'b1; m_tx[k] = 1'b1; m_done[k] = 1'b0;
        end
      end else begin
        m_t[k] = m_t[k] + 1;
        if (m_t[k] == frame_len(k)) begin
          m_busy[k] = 1'b0; m_rdy[k] = 1'b1; m_tx[k] = 1'b1; m_done[k] = 1'b0;
        end else begin
          m_tx[k]   = slot_level(k, m_t[k] / cpb_of(k), m_byte[k]);
          m_done[k] = (m_t[k] == frame_len(k) - 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if ({tx[k], ready[k], busy[k], done[k]} !== {m_tx[k], m_rdy[k], m_busy[k], m_done[k]}) begin
          n_bad++;
          $display("FAIL model inst %0d t=%0t: {tx,ready,busy,done}=%b required %b", k, $time,
                   {tx[k], ready[k], busy[k], done[k]}, {m_tx[k], m_rdy[k], m_busy[k], m_done[k]});
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (ready[k] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (ready[k] !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout inst %0d: ready=%b required 1", k, ready[k]);
    end
  endtask

  // Sends byte b and samples the frame at negedges; j=0 is the first cycle after acceptance.
  task automatic run_frame(input int k, input logic [7:0] b, input int nb, input bit poke,
                           output logic [15:0] bits, output logic first_tx, output int done_j,
                           output logic rdy_after, output int low_len, output int hi_after);
    int cpb;
    cpb = cpb_of(k);
    bits = '0; first_tx = 1'bx; done_j = -1; low_len = 0; hi_after = 0;
    wait_ready(k);
    dat[k] = b;
    valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0;
    dat[k] = ~b;
    for (int j = 0; j < nb * cpb; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) first_tx = tx[k];
      if (poke && j == 3 * cpb + 2) begin valid[k] = 1'b1; dat[k] = 8'hC3; end
      if (poke && j == 3 * cpb + 3) valid[k] = 1'b0;
      if (j % cpb == cpb / 2) bits[j / cpb] = tx[k];
      if (done[k] === 1'b1) done_j = j;
      if (tx[k] === 1'b0) low_len++;
      if (j >= 9 * cpb && tx[k] === 1'b1) hi_after++;
    end
    @(negedge clk);
    rdy_after = ready[k];
  endtask

  initial begin
    logic [15:0] bits;
    logic        first_tx, rdy_after, prev;
    int          done_j, low_len, hi_after, f1, f2, dn;

    rst = '1;
    valid = '0;
    for (int k = 0; k < 5; k++) dat[k] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({tx[0], ready[0], busy[0], done[0]}), 32'b1000);
    rst = '0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_ready", 32'(ready[0]), 32'd1);

    // Basic frame 0xA5
    run_frame(0, 8'hA5, 10, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("basic_start_latency", 32'(first_tx), 32'd0);
    check("basic_bits", 32'(bits[9:0]), 32'h34A);
    check("basic_done_pos", 32'(done_j), 32'd79);
    check("basic_ready_after", 32'(rdy_after), 32'd1);

    // Back-to-back 0x00 then 0xFF with valid held high
    wait_ready(0);
    dat[0] = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk);
    prev = 1'b1; f1 = -1; f2 = -1; dn = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (j == 0) dat[0] = 8'hFF;
      if (prev === 1'b1 && tx[0] === 1'b0) begin
        if (f1 < 0) f1 = j;
        else if (f2 < 0) begin f2 = j; valid[0] = 1'b0; end
      end
      prev = tx[0];
      if (done[0] === 1'b1) dn++;
    end
    valid[0] = 1'b0;
    check("b2b_spacing", 32'(f2 - f1), 32'd81);
    check("b2b_done_count", 32'(dn), 32'd2);

    // Parity
    run_frame(1, 8'h07, 11, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("even_07_parity", 32'(bits[9]), 32'd1);
    check("even_07_done_pos", 32'(done_j), 32'd87);
    run_frame(2, 8'h07, 11, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("odd_07_parity", 32'(bits[9]), 32'd0);
    run_frame(1, 8'h03, 11, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("even_03_parity", 32'(bits[9]), 32'd0);

    // Two stop bits
    run_frame(3, 8'h80, 11, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("stop2_msb", 32'(bits[8]), 32'd1);
    check("stop2_high_after_msb", 32'(hi_after), 32'd16);
    check("stop2_done_pos", 32'(done_j), 32'd87);

    // Reset during data bit 3
    wait_ready(0);
    dat[0] = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (34) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", 32'(tx[0]), 32'd1);
    check("midrst_ready", 32'(ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_ready_held", 32'(ready[0]), 32'd0);
    rst[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_release_ready", 32'(ready[0]), 32'd1);
    dn = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (done[0] === 1'b1 || busy[0] === 1'b1) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    run_frame(0, 8'h3C, 10, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("midrst_next_bits", 32'(bits[9:0]), 32'h278);

    // valid pulse and dat_i changes during DATA are ignored
    run_frame(0, 8'h5A, 10, 1'b1, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("ignored_bits", 32'(bits[9:0]), 32'h2B4);
    repeat (5) @(negedge clk);
    check("ignored_no_second_frame", 32'({ready[0], busy[0]}), 32'b10);

    // Default parameters: start bit is exactly 217 clocks
    run_frame(4, 8'hFF, 10, 1'b0, bits, first_tx, done_j, rdy_after, low_len, hi_after);
    check("default_start_latency", 32'(first_tx), 32'd0);
    check("default_bit_width", 32'(low_len), 32'd217);
    check("default_done_pos", 32'(done_j), 32'd2169);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
